// File: rtl/exc_pkg.sv
// Shared exception-unit definitions: FSM state encoding, EStatus cause
// codes and the cause priority encoder.
package exc_pkg;

  localparam int unsigned CAUSE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_HANDLER = 2'd2
  } exc_state_e;

  localparam logic [CAUSE_W-1:0] EXC_NONE  = 4'b0000;
  localparam logic [CAUSE_W-1:0] EXC_IRQ   = 4'b0001;
  localparam logic [CAUSE_W-1:0] EXC_BADOP = 4'b0010;
  localparam logic [CAUSE_W-1:0] EXC_TIMER = 4'b0100;

  // Highest-priority active cause: badOpcode > timer > irq.
  function automatic logic [CAUSE_W-1:0] exc_prio(input logic badop,
                                                   input logic timer,
                                                   input logic irq);
    logic [CAUSE_W-1:0] code;
    code = EXC_NONE;
    if (badop)      code = EXC_BADOP;
    else if (timer) code = EXC_TIMER;
    else if (irq)   code = EXC_IRQ;
    return code;
  endfunction

endpackage

// File: rtl/exc_timer.sv
// Free-running periodic timer. Counts 0..TIMER_PERIOD-1 and wraps; tick is a
// registered one-cycle pulse following each wrap edge.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   tick  - one-cycle pulse, high for the cycle after the counter wraps
module exc_timer #(
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned TIMER_PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_PERIOD - 1);

  logic [TIMER_W-1:0] count;

  // Counter with wrap; tick marks the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + TIMER_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/exc_unit.sv
// Exception controller: samples irq / badOpcode (and an optional periodic
// timer), raises Exc to the datapath, tracks the handler window and flags
// double faults.
// Optional feature macro: EXC_TIMER_EN (adds exc_timer and the timer cause).
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-low reset
//   irq         - level interrupt request (not latched)
//   badOpcode   - current instruction invalid
//   ExcAck      - datapath took the exception vector
//   ERet        - current instruction is ERET
//   Exc         - exception request (high exactly while pending)
//   EStatus     - cause code of the pending/taken exception
//   inHandler   - handler active, causes masked
//   doubleFault - sticky: badOpcode seen while in the handler
module exc_unit
  import exc_pkg::*;
#(
  parameter int unsigned N            = 64,
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned TIMER_PERIOD = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irq,
  input  logic               badOpcode,
  input  logic               ExcAck,
  input  logic               ERet,
  output logic               Exc,
  output logic [CAUSE_W-1:0] EStatus,
  output logic               inHandler,
  output logic               doubleFault
);

  // Elaboration-time parameter sanity checks.
  if (N < 1) begin : g_bad_n
    $error("exc_unit: N must be at least 1");
  end
  if (TIMER_PERIOD < 1 || (TIMER_PERIOD >> TIMER_W) != 0) begin : g_bad_period
    $error("exc_unit: TIMER_PERIOD must be in 1..2^TIMER_W-1");
  end

  exc_state_e         state, state_nxt;
  logic [CAUSE_W-1:0] estatus_nxt;
  logic               dfault_nxt;
  logic               timer_cause_c;
  logic [CAUSE_W-1:0] cause_code_c;

  assign cause_code_c = exc_prio(badOpcode, timer_cause_c, irq);

`ifdef EXC_TIMER_EN
  logic tick;
  logic timer_pend;
  logic timer_take_c;

  exc_timer #(
    .TIMER_W      (TIMER_W),
    .TIMER_PERIOD (TIMER_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Timer cause is latched only from IDLE; that edge consumes the pending bit.
  assign timer_take_c  = (state == ST_IDLE) && (cause_code_c == EXC_TIMER);
  assign timer_cause_c = tick | timer_pend;

  // Pending bit: set by ticks (merged while set), cleared when taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            timer_pend <= 1'b0;
    else if (timer_take_c) timer_pend <= 1'b0;
    else if (tick)         timer_pend <= 1'b1;
  end
`else
  assign timer_cause_c = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      Exc         <= 1'b0;
      EStatus     <= EXC_NONE;
      inHandler   <= 1'b0;
      doubleFault <= 1'b0;
    end else begin
      state       <= state_nxt;
      Exc         <= (state_nxt == ST_PEND);
      EStatus     <= estatus_nxt;
      inHandler   <= (state_nxt == ST_HANDLER);
      doubleFault <= dfault_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt   = state;
    estatus_nxt = EStatus;
    dfault_nxt  = doubleFault;
    unique case (state)
      ST_IDLE: begin
        if (cause_code_c != EXC_NONE) begin
          state_nxt   = ST_PEND;
          estatus_nxt = cause_code_c;
        end
      end
      ST_PEND: begin
        if (ExcAck) state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (badOpcode) dfault_nxt = 1'b1;
        // Return takes precedence; any new cause is seen from IDLE next edge.
        if (ERet) begin
          state_nxt   = ST_IDLE;
          estatus_nxt = EXC_NONE;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        estatus_nxt = EXC_NONE;
      end
    endcase
  end

endmodule
